// File: rtl/seq_alu_if.sv
// Request/response bundle between the operand source and the sequential ALU.
interface seq_alu_if #(
  parameter int unsigned N = 8
) ();
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [3:0]   sel;
  logic         busy;
  logic         done;
  logic [N-1:0] out;
  logic         Z;
  logic         O;
  logic         Ca;
  logic         Neg;
  logic         err;

  modport master (
    output start, A, B, sel,
    input  busy, done, out, Z, O, Ca, Neg, err
  );

  modport slave (
    input  start, A, B, sel,
    output busy, done, out, Z, O, Ca, Neg, err
  );
endinterface

// File: rtl/seq_alu.sv
// Registered N-bit ALU with start/done handshake. Single-cycle ops load at the
// accepting edge; mul/div/mod iterate once per cycle for N cycles.
module seq_alu #(
  parameter int unsigned N = 8
) (
  input logic     clk,
  input logic     rst,
  seq_alu_if.slave bus
);

  localparam int unsigned CntW = $clog2(N);

  localparam logic [3:0] OpAdd = 4'h0;
  localparam logic [3:0] OpSub = 4'h1;
  localparam logic [3:0] OpMul = 4'h2;
  localparam logic [3:0] OpDiv = 4'h3;
  localparam logic [3:0] OpMod = 4'h4;
  localparam logic [3:0] OpShl = 4'h5;
  localparam logic [3:0] OpShr = 4'h6;
  localparam logic [3:0] OpAnd = 4'h7;
  localparam logic [3:0] OpXor = 4'h8;
  localparam logic [3:0] OpOr  = 4'h9;

  typedef enum logic [0:0] {StIdle, StCalc} state_e;

  state_e          state_q;
  logic [N-1:0]    a_q, b_q;
  logic [3:0]      sel_q;
  logic [CntW-1:0] cnt_q;
  logic [2*N:0]    prod_q, prod_nxt;
  logic [N-1:0]    rem_q, rem_nxt, quo_q, quo_nxt;
  logic [N-1:0]    out_q;
  logic            z_q, o_q, ca_q, neg_q, err_q, busy_q, done_q;

  logic            is_iter;
  logic [N:0]      add_w, sub_w, shl_w, shr_w;
  logic [N-1:0]    fast_out;
  logic            fast_o, fast_ca, fast_err;

  logic [N:0]      hi_sum, rem_sh, rem_sel;
  logic            rem_ge;
  logic [N-1:0]    iter_out;
  logic            iter_o;
  logic            unused_bits;

  assign is_iter = (bus.sel == OpMul) || (bus.sel == OpDiv) || (bus.sel == OpMod);

  // Single-cycle result straight from the bus operands, loaded at the accepting edge.
  always_comb begin
    // Widened by one bit so the carry/borrow/shifted-out bit falls out of the MSB/LSB.
    add_w    = {1'b0, bus.A} + {1'b0, bus.B};
    sub_w    = {1'b0, bus.A} - {1'b0, bus.B};
    shl_w    = {1'b0, bus.A} << bus.B;
    shr_w    = {bus.A, 1'b0} >> bus.B;
    fast_out = '0;
    fast_o   = 1'b0;
    fast_ca  = 1'b0;
    fast_err = 1'b0;
    case (bus.sel)
      OpAdd: begin
        fast_out = add_w[N-1:0];
        fast_ca  = add_w[N];
        fast_o   = (bus.A[N-1] == bus.B[N-1]) && (add_w[N-1] != bus.A[N-1]);
      end
      OpSub: begin
        fast_out = sub_w[N-1:0];
        fast_ca  = sub_w[N];
        fast_o   = (bus.A[N-1] != bus.B[N-1]) && (sub_w[N-1] != bus.A[N-1]);
      end
      OpShl: begin
        fast_out = shl_w[N-1:0];
        fast_ca  = shl_w[N];
      end
      OpShr: begin
        fast_out = shr_w[N:1];
        fast_ca  = shr_w[0];
      end
      OpAnd: fast_out = bus.A & bus.B;
      OpXor: fast_out = bus.A ^ bus.B;
      OpOr:  fast_out = bus.A | bus.B;
      OpMul, OpDiv, OpMod: fast_out = '0;
      default: fast_err = 1'b1;
    endcase
  end

  // One shift-add multiply step and one restoring-divide step per cycle.
  always_comb begin
    hi_sum   = prod_q[2*N:N] + {1'b0, (prod_q[0] ? a_q : {N{1'b0}})};
    prod_nxt = {hi_sum, prod_q[N-1:0]} >> 1;
    rem_sh   = {rem_q, quo_q[N-1]};
    rem_ge   = rem_sh >= {1'b0, b_q};
    rem_sel  = rem_ge ? (rem_sh - {1'b0, b_q}) : rem_sh;
    // With B=0 every step "fits": quotient saturates to all ones, remainder ends as A.
    rem_nxt  = rem_sel[N-1:0];
    quo_nxt  = {quo_q[N-2:0], rem_ge};
    iter_out = rem_nxt;
    iter_o   = ~|b_q;
    case (sel_q)
      OpMul: begin
        iter_out = prod_nxt[N-1:0];
        iter_o   = |prod_nxt[2*N-1:N];
      end
      OpDiv:   iter_out = quo_nxt;
      default: iter_out = rem_nxt;
    endcase
  end

  assign unused_bits = prod_nxt[2*N] ^ rem_sel[N];

  // Control FSM plus registered result/flags; all outputs change only at result load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      out_q   <= '0;
      z_q     <= 1'b0;
      o_q     <= 1'b0;
      ca_q    <= 1'b0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            a_q   <= bus.A;
            b_q   <= bus.B;
            sel_q <= bus.sel;
            if (is_iter) begin
              state_q <= StCalc;
              busy_q  <= 1'b1;
              cnt_q   <= '0;
              prod_q  <= {{(N+1){1'b0}}, bus.B};
              rem_q   <= '0;
              quo_q   <= bus.A;
            end else begin
              out_q  <= fast_out;
              z_q    <= ~|fast_out;
              neg_q  <= fast_out[N-1];
              o_q    <= fast_o;
              ca_q   <= fast_ca;
              err_q  <= fast_err;
              done_q <= 1'b1;
            end
          end
        end
        StCalc: begin
          prod_q <= prod_nxt;
          rem_q  <= rem_nxt;
          quo_q  <= quo_nxt;
          cnt_q  <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(N - 1)) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            out_q   <= iter_out;
            z_q     <= ~|iter_out;
            neg_q   <= iter_out[N-1];
            o_q     <= iter_o;
            ca_q    <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.out  = out_q;
  assign bus.Z    = z_q;
  assign bus.O    = o_q;
  assign bus.Ca   = ca_q;
  assign bus.Neg  = neg_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: driver pushes model results, monitor pops on done.
module tb_seq_alu;

  localparam int N = 8;

  typedef struct packed {
    logic [N-1:0] out;
    logic         z;
    logic         o;
    logic         ca;
    logic         neg;
    logic         err;
  } res_t;

  typedef struct {
    res_t r;
    int   exp_cyc;
  } item_t;

  logic clk = 1'b0;
  logic rst;

  seq_alu_if #(.N(N)) bus ();

  seq_alu #(.N(N)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  item_t sbq[$];
  res_t  last;
  int    cyc = 0;
  int    busy_lo = 0;
  int    busy_hi = 0;
  int    total = 0;
  int    bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint sgn(input logic [N-1:0] v);
    return v[N-1] ? longint'(v) - (longint'(1) << N) : longint'(v);
  endfunction

  // Reference behaviour from the opcode rules using plain integer arithmetic.
  function automatic res_t model(input logic [3:0] op, input logic [N-1:0] a,
                                 input logic [N-1:0] b);
    longint unsigned m  = 64'd1 << N;
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    longint unsigned r  = 0;
    longint          hm = longint'(m >> 1);
    longint          sr;
    res_t            x;
    x = '0;
    case (op)
      4'd0: begin
        r = ua + ub;
        x.ca = r >= m;
        sr = sgn(a) + sgn(b);
        x.o = (sr < -hm) || (sr >= hm);
      end
      4'd1: begin
        r = ua - ub;
        x.ca = ua < ub;
        sr = sgn(a) - sgn(b);
        x.o = (sr < -hm) || (sr >= hm);
      end
      4'd2: begin
        r = ua * ub;
        x.o = r >= m;
      end
      4'd3: begin
        if (ub == 0) begin r = m - 1; x.o = 1'b1; end
        else r = ua / ub;
      end
      4'd4: begin
        if (ub == 0) begin r = ua; x.o = 1'b1; end
        else r = ua % ub;
      end
      4'd5: begin
        if (ub == 0) r = ua;
        else if (ub <= N) begin
          r = ua << ub;
          x.ca = 1'((ua >> (N - ub)) & 64'd1);
        end else r = 0;
      end
      4'd6: begin
        if (ub == 0) r = ua;
        else if (ub <= N) begin
          r = ua >> ub;
          x.ca = 1'((ua >> (ub - 1)) & 64'd1);
        end else r = 0;
      end
      4'd7: r = ua & ub;
      4'd8: r = ua ^ ub;
      4'd9: r = ua | ub;
      default: begin
        r = 0;
        x.err = 1'b1;
      end
    endcase
    r = r % m;
    x.out = r[N-1:0];
    x.z   = (x.out == '0);
    x.neg = x.out[N-1];
    return x;
  endfunction

  function automatic res_t dut_res();
    return {bus.out, bus.Z, bus.O, bus.Ca, bus.Neg, bus.err};
  endfunction

  // Drive one request at a negedge once the ALU is idle; expected result goes to the queue.
  task automatic send(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    item_t it;
    bit    iter;
    @(negedge clk);
    for (int i = 0; i < 64 && bus.busy; i++) begin
      bus.start = 1'b0;
      @(negedge clk);
    end
    if (bus.busy) check("accept_timeout", 1, 0);
    iter = (op == 4'd2) || (op == 4'd3) || (op == 4'd4);
    bus.start = 1'b1;
    bus.sel   = op;
    bus.A     = a;
    bus.B     = b;
    it.r       = model(op, a, b);
    it.exp_cyc = cyc + 1 + (iter ? N : 0);
    sbq.push_back(it);
    if (iter) begin
      busy_lo = cyc + 1;
      busy_hi = cyc + 1 + N;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask

  task automatic do_reset(input bit with_start);
    @(negedge clk);
    rst       = 1'b1;
    bus.start = with_start;
    bus.sel   = 4'd0;
    bus.A     = N'($urandom);
    sbq.delete();
    busy_hi   = 0;
    last      = '0;
    @(negedge clk);
    check("reset_outputs", longint'({bus.busy, bus.done, dut_res()}), 0);
    rst       = 1'b0;
    bus.start = 1'b0;
  endtask

  // Monitor: every cycle check busy, then either match a done against the queue
  // or confirm the outputs held their last loaded values.
  initial begin
    item_t it;
    last = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst) continue;
      check("busy", longint'(bus.busy), longint'(cyc >= busy_lo && cyc < busy_hi));
      if (bus.done) begin
        if (sbq.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          it = sbq.pop_front();
          check("done_latency", cyc, it.exp_cyc);
          check("result", longint'(dut_res()), longint'(it.r));
          last = it.r;
        end
      end else begin
        check("held_outputs", longint'(dut_res()), longint'(last));
        if (sbq.size() > 0 && sbq[0].exp_cyc <= cyc) begin
          it = sbq.pop_front();
          check("missing_done", 0, 1);
        end
      end
    end
  end

  initial begin
    logic [3:0]   op;
    logic [N-1:0] a, b;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.sel   = '0;
    repeat (3) @(negedge clk);
    check("reset_state", longint'({bus.busy, bus.done, dut_res()}), 0);
    rst = 1'b0;

    send(4'd0, 8'h7F, 8'h01);
    idle(1);
    send(4'd1, 8'h02, 8'h0D);
    send(4'd5, 8'h81, 8'd1);
    send(4'd6, 8'h03, 8'd9);
    send(4'd2, 8'h13, 8'h11);
    // Extra starts with fresh operands while busy must be ignored.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.start = 1'b1;
      bus.sel   = 4'd0;
      bus.A     = N'($urandom);
      bus.B     = N'($urandom);
    end
    idle(1);
    send(4'd3, 8'd200, 8'd7);
    send(4'd4, 8'd200, 8'd7);
    send(4'd3, 8'd200, 8'd0);
    send(4'd4, 8'h05, 8'd0);
    idle(1);
    send(4'd7, 8'h06, 8'h0B);
    send(4'd8, 8'h06, 8'h0B);
    send(4'd9, 8'h06, 8'h0B);
    idle(2);

    // Reset partway through a multiply abandons it; reset also beats start.
    send(4'd2, 8'hF3, 8'h57);
    idle(3);
    do_reset(1'b1);
    send(4'hF, 8'h12, 8'h34);
    send(4'd7, 8'hF0, 8'h3C);
    idle(1);

    for (int n = 0; n < 300; n++) begin
      op = 4'($urandom_range(0, 15));
      a  = N'($urandom);
      case ($urandom_range(0, 3))
        0:       b = N'($urandom_range(0, N + 2));
        1:       b = '0;
        default: b = N'($urandom);
      endcase
      send(op, a, b);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(1);

    for (int i = 0; i < 40 && sbq.size() > 0; i++) @(negedge clk);
    check("drain", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered N-bit ALU with a start/done handshake and latched status flags. It keeps the team's 4-bit ALU opcode map and flag set (Z, O, Ca, Neg). Multiply, divide and modulo run iteratively over N cycles; all other operations complete in one cycle. It sits between the operand/opcode source (switch/register front end) and the display/flag consumers.

## Interface
- N, 8, data width; power of two, 4..32
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; sampled only when busy=0
- A  in  N  operand A (unsigned unless stated)
- B  in  N  operand B
- sel  in  4  opcode: 0000 add, 0001 sub, 0010 mul, 0011 div, 0100 mod, 0101 shl, 0110 shr, 0111 and, 1000 xor, 1001 or
- busy  out  1  iterative operation in progress
- done  out  1  one-cycle pulse: out/flags just updated
- out  out  N  result, held until next done
- Z  out  1  out == 0
- O  out  1  overflow (see Operation)
- Ca  out  1  carry/borrow/shifted-out bit
- Neg  out  1  out[N-1]
- err  out  1  illegal opcode on last completed request

## Operation
- States: IDLE, CALC. A, B and sel latched on acceptance (start=1 in IDLE); later input changes have no effect on that request.
- Fast ops (add, sub, shl, shr, and, xor, or, illegal): IDLE→IDLE, result loaded at the accepting edge.
- mul/div/mod: IDLE→CALC, N-iteration shift-add multiply / restoring divide, CALC→IDLE on the last iteration with result load.
- add: out = A+B mod 2^N; Ca = carry out; O = signed overflow.
- sub: out = A−B mod 2^N; Ca = borrow (A<B unsigned); O = signed overflow.
- mul: out = low N bits of the 2N-bit unsigned product; O = 1 if high N bits ≠ 0; Ca = 0.
- div: out = floor(A/B); mod: out = A mod B; Ca = O = 0. B=0: div out = all ones, mod out = A, O = 1.
- shl/shr (logical): shift amount = B unsigned. B=0: out = A, Ca = 0. 1≤B≤N: Ca = last bit shifted out. B>N: out = 0, Ca = 0.
- and/xor/or: bitwise; Ca = O = 0.
- Opcodes 1010..1111: out = 0, err = 1, Ca = O = 0. err = 0 for every legal opcode.
- Z and Neg are always derived from the loaded out. All outputs update together, only at result load.
- start while busy=1 is ignored (no queueing).

## Timing
- Reset: state IDLE; out = 0; Z, O, Ca, Neg, err, busy, done = 0. Reset dominates start. Reset mid-CALC abandons the operation with no done pulse.
- Fast op accepted at edge E0: results and done=1 visible in the cycle after E0. done lasts exactly one cycle. A new start is sampled at E1, so start held high gives one result per cycle.
- Iterative op accepted at E0: busy=1 from after E0 until after E(N−1). Result load and done=1 occur after edge E(N), with busy=0 in the same cycle. Latency = N cycles. Next acceptance is possible at E(N+1).
- Outputs are stable between done pulses.

## Test plan
- Reset, then add A=0x7F B=0x01 start 1 cycle → next cycle done=1, out=0x80, O=1, Neg=1, Ca=0, Z=0; after reset all outputs are 0.
- sub A=0x02 B=0x0D → out=0xF5, Ca=1, Neg=1, O=0. Then shl A=0x81 B=1 → out=0x02, Ca=1. Then shr A=0x03 B=9 → out=0x00, Z=1, Ca=0.
- mul A=0x13 B=0x11 → done exactly 8 cycles after acceptance, out=0x43, O=1. Extra start pulses and A changes during busy are ignored: exactly one done.
- div A=200 B=7 → out=0x1C. mod A=200 B=7 → out=0x04. div B=0 → out=0xFF, O=1. mod A=0x05 B=0 → out=0x05, O=1.
- start held high for 3 cycles with sel and, xor, or on A=0x06 B=0x0B → three consecutive done pulses, out=0x02, 0x0D, 0x0F.
- rst asserted at cycle 4 of a mul → no done, outputs 0. A subsequent sel=1111 → out=0, err=1, Z=1. A following and → err=0.
